// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the RV32 add/addi/lw/sw/lui datapath: walks FETCH..WRITEBACK,
// handles memory request/ready handshakes, a bus watchdog, a retired counter and a sticky trap.
module multicycle_controller #(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instructionCode,
  input  logic               imemReady,
  input  logic               dmemReady,
  output logic               imemReq,
  output logic               dmemReq,
  output logic               IRWEn,
  output logic               PCWEn,
  output logic [1:0]         ImmSel,
  output logic               RegWEn,
  output logic               BSel,
  output logic [3:0]         ALUSel,
  output logic               MemRW,
  output logic               WBSel,
  output logic               illegalInstr,
  output logic               busError,
  output logic [2:0]         stateOut,
  output logic [COUNT_W-1:0] retiredCount
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [6:0]           opcode_q, opcode_d;
  logic [WAIT_W-1:0]    wait_q, wait_d, wait_next;
  logic [COUNT_W-1:0]   retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;

  logic                 wait_inc;
  logic                 imem_req, dmem_req, ir_wen, pc_wen, reg_wen, mem_rw;
  logic                 b_sel, wb_sel;
  logic [1:0]           imm_sel;
  logic [3:0]           alu_sel;

  logic [1:0]           f_imm;
  logic                 f_bsel, f_wb;
  logic [3:0]           f_alu;
  logic                 is_sw, op_legal;

  logic                 unused_instr_bits;
  assign unused_instr_bits = ^instructionCode[31:7];

  // Datapath fields derived from the latched opcode; only meaningful once past DECODE.
  always_comb begin
    f_imm  = 2'b00;
    f_bsel = 1'b1;
    f_alu  = 4'b0010;
    f_wb   = 1'b1;
    case (opcode_q)
      OP_ADD:  f_bsel = 1'b0;
      OP_LW:   begin f_imm = 2'b01; f_wb = 1'b0; end
      OP_SW:   begin f_imm = 2'b10; f_wb = 1'b0; end
      OP_LUI:  begin f_imm = 2'b11; f_alu = 4'b0110; end
      default: ;
    endcase
  end

  assign is_sw    = (opcode_q == OP_SW);
  assign op_legal = (instructionCode[6:0] inside {OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_LUI});

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_inc  = 1'b0;
    wait_next = wait_q + WAIT_W'(1);
    wait_d    = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_wen    = 1'b0;
    pc_wen    = 1'b0;
    reg_wen   = 1'b0;
    mem_rw    = 1'b0;
    imm_sel   = 2'b00;
    b_sel     = 1'b0;
    alu_sel   = 4'b0000;
    wb_sel    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imemReady) begin
          ir_wen  = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        opcode_d = instructionCode[6:0];
        if (op_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        imm_sel = f_imm;
        b_sel   = f_bsel;
        alu_sel = f_alu;
        wb_sel  = f_wb;
        state_d = (opcode_q == OP_LW || is_sw) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        imm_sel  = f_imm;
        b_sel    = f_bsel;
        alu_sel  = f_alu;
        wb_sel   = f_wb;
        dmem_req = 1'b1;
        mem_rw   = is_sw;
        if (dmemReady) begin
          if (is_sw) begin
            pc_wen    = 1'b1;
            retired_d = retired_q + COUNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        imm_sel   = f_imm;
        b_sel     = f_bsel;
        alu_sel   = f_alu;
        wb_sel    = f_wb;
        reg_wen   = 1'b1;
        pc_wen    = 1'b1;
        retired_d = retired_q + COUNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_TRAP;
    endcase

    // Watchdog only fires on a cycle still waiting, so a same-cycle ready always wins.
    if (wait_inc && (MEM_TIMEOUT != 0) && (wait_next == WAIT_W'(MEM_TIMEOUT))) begin
      state_d   = S_TRAP;
      bus_err_d = 1'b1;
    end
    if (wait_inc && (state_d == state_q)) begin
      wait_d = wait_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every output is held low for as long as reset is asserted.
  assign imemReq      = imem_req & ~rst;
  assign dmemReq      = dmem_req & ~rst;
  assign IRWEn        = ir_wen & ~rst;
  assign PCWEn        = pc_wen & ~rst;
  assign RegWEn       = reg_wen & ~rst;
  assign MemRW        = mem_rw & ~rst;
  assign BSel         = b_sel & ~rst;
  assign WBSel        = wb_sel & ~rst;
  assign ImmSel       = rst ? 2'b00 : imm_sel;
  assign ALUSel       = rst ? 4'b0000 : alu_sel;
  assign illegalInstr = illegal_q & ~rst;
  assign busError     = bus_err_q & ~rst;
  assign stateOut     = rst ? 3'd0 : state_q;
  assign retiredCount = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: builds per-cycle expected traces from the
// instruction timing rules and compares two instances (watchdog 4 / 32-bit, no watchdog / 2-bit).
module tb_multicycle_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instructionCode;
  logic        imemReady, dmemReady;

  logic        imemReq, dmemReq, IRWEn, PCWEn, RegWEn, BSel, MemRW, WBSel, illegalInstr, busError;
  logic [1:0]  ImmSel;
  logic [3:0]  ALUSel;
  logic [2:0]  stateOut;
  logic [31:0] retiredCount;

  logic        imemReq_b, dmemReq_b, IRWEn_b, PCWEn_b, RegWEn_b, BSel_b, MemRW_b, WBSel_b;
  logic        illegalInstr_b, busError_b;
  logic [1:0]  ImmSel_b;
  logic [3:0]  ALUSel_b;
  logic [2:0]  stateOut_b;
  logic [1:0]  retiredCount_b;

  multicycle_controller #(.COUNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instructionCode(instructionCode),
    .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .dmemReq(dmemReq), .IRWEn(IRWEn), .PCWEn(PCWEn),
    .ImmSel(ImmSel), .RegWEn(RegWEn), .BSel(BSel), .ALUSel(ALUSel),
    .MemRW(MemRW), .WBSel(WBSel), .illegalInstr(illegalInstr), .busError(busError),
    .stateOut(stateOut), .retiredCount(retiredCount)
  );

  multicycle_controller #(.COUNT_W(2), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .instructionCode(instructionCode),
    .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq_b), .dmemReq(dmemReq_b), .IRWEn(IRWEn_b), .PCWEn(PCWEn_b),
    .ImmSel(ImmSel_b), .RegWEn(RegWEn_b), .BSel(BSel_b), .ALUSel(ALUSel_b),
    .MemRW(MemRW_b), .WBSel(WBSel_b), .illegalInstr(illegalInstr_b), .busError(busError_b),
    .stateOut(stateOut_b), .retiredCount(retiredCount_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       imr, dmr, irw, pcw, rw, mrw;
    logic [1:0] imm;
    logic       bs;
    logic [3:0] alu;
    logic       wb, ill, be;
  } ov_t;

  typedef struct packed {
    logic [31:0] ic;
    logic        ir;
    logic        dr;
  } in_t;

  ov_t exp_q[$];
  ov_t msk_q[$];
  ov_t obs_q[$];
  ov_t obs_b_q[$];
  in_t in_q[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned m_ret  = 0;

  function automatic ov_t pack_a();
    ov_t v;
    v.st = stateOut; v.imr = imemReq; v.dmr = dmemReq; v.irw = IRWEn; v.pcw = PCWEn;
    v.rw = RegWEn; v.mrw = MemRW; v.imm = ImmSel; v.bs = BSel; v.alu = ALUSel;
    v.wb = WBSel; v.ill = illegalInstr; v.be = busError;
    return v;
  endfunction

  function automatic ov_t pack_b();
    ov_t v;
    v.st = stateOut_b; v.imr = imemReq_b; v.dmr = dmemReq_b; v.irw = IRWEn_b; v.pcw = PCWEn_b;
    v.rw = RegWEn_b; v.mrw = MemRW_b; v.imm = ImmSel_b; v.bs = BSel_b; v.alu = ALUSel_b;
    v.wb = WBSel_b; v.ill = illegalInstr_b; v.be = busError_b;
    return v;
  endfunction

  // 0 add, 1 addi, 2 lw, 3 sw, 4 lui, 5 unsupported
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'h33:   return 0;
      7'h13:   return 1;
      7'h03:   return 2;
      7'h23:   return 3;
      7'h37:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic ov_t fields(input int cls);
    ov_t v;
    v     = '0;
    v.bs  = (cls != 0);
    v.alu = (cls == 4) ? 4'b0110 : 4'b0010;
    v.wb  = (cls == 0 || cls == 1 || cls == 4);
    v.imm = (cls == 2) ? 2'b01 : (cls == 3) ? 2'b10 : (cls == 4) ? 2'b11 : 2'b00;
    return v;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.ic = $urandom;
    x.ir = 1'($urandom);
    x.dr = 1'($urandom);
    return x;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [6:0]  ops [5];
    logic [31:0] w;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h37;
    w      = $urandom;
    w[6:0] = ops[$urandom_range(0, 4)];
    return w;
  endfunction

  task automatic push(input ov_t v, input ov_t m, input in_t x);
    exp_q.push_back(v);
    msk_q.push_back(m);
    in_q.push_back(x);
  endtask

  task automatic trap(input logic ill, input logic be, input int n);
    ov_t v;
    for (int k = 0; k < n; k++) begin
      v = '0; v.st = 3'd5; v.ill = ill; v.be = be;
      push(v, '1, rnd_in());
    end
  endtask

  // Expected per-cycle trace of one instruction: iw fetch waits, dw data waits, ntrap trap cycles.
  task automatic gen(input logic [31:0] w, input int iw, input int dw, input int ntrap);
    int  cls;
    ov_t f, v, m;
    in_t x;
    cls = classify(w[6:0]);
    f   = fields(cls);
    m   = '1;
    if (cls == 3) m.wb = 1'b0;
    for (int k = 0; k < iw && k < TO; k++) begin
      v = '0; v.imr = 1'b1;
      x = rnd_in(); x.ir = 1'b0;
      push(v, '1, x);
    end
    if (iw >= TO) begin
      trap(1'b0, 1'b1, ntrap);
      return;
    end
    v = '0; v.imr = 1'b1; v.irw = 1'b1;
    x = rnd_in(); x.ir = 1'b1;
    push(v, '1, x);
    v = '0; v.st = 3'd1;
    x = rnd_in(); x.ic = w;
    push(v, '1, x);
    if (cls == 5) begin
      trap(1'b1, 1'b0, ntrap);
      return;
    end
    v = f; v.st = 3'd2;
    push(v, m, rnd_in());
    if (cls == 2 || cls == 3) begin
      for (int k = 0; k < dw && k < TO; k++) begin
        v = f; v.st = 3'd3; v.dmr = 1'b1; v.mrw = (cls == 3);
        x = rnd_in(); x.dr = 1'b0;
        push(v, m, x);
      end
      if (dw >= TO) begin
        trap(1'b0, 1'b1, ntrap);
        return;
      end
      v = f; v.st = 3'd3; v.dmr = 1'b1; v.mrw = (cls == 3); v.pcw = (cls == 3);
      x = rnd_in(); x.dr = 1'b1;
      push(v, m, x);
    end
    if (cls != 3) begin
      v = f; v.st = 3'd4; v.rw = 1'b1; v.pcw = 1'b1;
      push(v, m, rnd_in());
    end
    m_ret++;
  endtask

  task automatic play();
    for (int i = obs_q.size(); i < in_q.size(); i++) begin
      instructionCode = in_q[i].ic;
      imemReady       = in_q[i].ir;
      dmemReady       = in_q[i].dr;
      @(negedge clk);
      obs_q.push_back(pack_a());
      obs_b_q.push_back(pack_b());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    exp_q.delete(); msk_q.delete(); obs_q.delete(); obs_b_q.delete(); in_q.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    imemReady = 1'b1;
    dmemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ret = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imemReady = 1'b1; dmemReady = 1'b1; instructionCode = 32'h00500093;
    @(negedge clk);
    checks++;
    if (pack_a() !== ov_t'(0) || retiredCount !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got %h cnt %0d required 0", pack_a(), retiredCount);
    end
    checks++;
    if (pack_b() !== ov_t'(0) || retiredCount_b !== 2'd0) begin
      errors++; $display("FAIL reset_outputs_b got %h cnt %0d required 0", pack_b(), retiredCount_b);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (stateOut !== 3'd0 || imemReq !== 1'b1 || retiredCount !== 32'd0) begin
      errors++; $display("FAIL reset_release state %0d imemReq %b cnt %0d required 0 1 0", stateOut, imemReq, retiredCount);
    end
    m_ret = 0;
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_addi();
    clear();
    gen(32'h00500093, 0, 0, 0);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL addi cycle %0d got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (retiredCount !== m_ret) begin
      errors++; $display("FAIL addi_retired got %0d required %0d", retiredCount, m_ret);
    end
    $display("test_addi done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lw_wait();
    clear();
    gen(32'h00402103, 0, 3, 0);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL lw_wait cycle %0d got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() != 8 || retiredCount !== m_ret) begin
      errors++; $display("FAIL lw_wait_len cycles %0d cnt %0d required 8 %0d", obs_q.size(), retiredCount, m_ret);
    end
    $display("test_lw_wait done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_sw_lui();
    clear();
    gen(32'h00202223, 0, 0, 0);
    gen(32'h123450b7, 0, 0, 0);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL sw_lui cycle %0d got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (retiredCount !== m_ret) begin
      errors++; $display("FAIL sw_lui_retired got %0d required %0d", retiredCount, m_ret);
    end
    $display("test_sw_lui done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    clear();
    for (int n = 0; n < 40; n++) begin
      gen(rand_legal(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 0);
      play();
      checks++;
      if (retiredCount !== m_ret || retiredCount_b !== m_ret[1:0]) begin
        errors++; $display("FAIL random_retired instr %0d got %0d/%0d required %0d", n, retiredCount, retiredCount_b, m_ret);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]) ||
          (obs_b_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL random cycle %0d got %h / %h required %h", i, obs_q[i], obs_b_q[i], exp_q[i]);
      end
    end
    $display("test_random done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin
        w = 32'h0000007f;
      end else begin
        w = $urandom;
        while (classify(w[6:0]) != 5) w = $urandom;
      end
      do_reset();
      clear();
      gen(w, $urandom_range(0, 2), 0, 20);
      play();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          errors++; $display("FAIL illegal op %h cycle %0d got %h required %h", w[6:0], i, obs_q[i], exp_q[i]);
        end
      end
    end
    do_reset();
    #1;
    checks++;
    if (stateOut !== 3'd0 || illegalInstr !== 1'b0 || imemReq !== 1'b1) begin
      errors++; $display("FAIL illegal_cleared state %0d ill %b req %b required 0 0 1", stateOut, illegalInstr, imemReq);
    end
    $display("test_illegal done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_timeout();
    do_reset();
    clear();
    gen(32'h00500093, TO, 0, 5);
    play();
    checks++;
    if (obs_b_q[TO].st !== 3'd0 || obs_b_q[TO].be !== 1'b0) begin
      errors++; $display("FAIL no_watchdog state %0d be %b required 0 0", obs_b_q[TO].st, obs_b_q[TO].be);
    end
    do_reset();
    gen(32'h00500093, TO - 1, 0, 0);
    gen(32'h00402103, 0, TO, 4);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL timeout cycle %0d got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_timeout done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear();
    gen(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    gen(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    gen(32'h00500093, 0, 0, 0);
    void'(exp_q.pop_back()); void'(msk_q.pop_back()); void'(in_q.pop_back());
    play();
    checks++;
    if (stateOut !== 3'd4 || RegWEn !== 1'b1) begin
      errors++; $display("FAIL mid_in_wb state %0d RegWEn %b required 4 1", stateOut, RegWEn);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pack_a() !== ov_t'(0) || retiredCount !== 32'd0) begin
      errors++; $display("FAIL mid_reset got %h cnt %0d required 0", pack_a(), retiredCount);
    end
    @(negedge clk);
    checks++;
    if (pack_a() !== ov_t'(0) || retiredCount !== 32'd0) begin
      errors++; $display("FAIL mid_reset_hold got %h cnt %0d required 0", pack_a(), retiredCount);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ret = 0;
    #1;
    checks++;
    if (stateOut !== 3'd0 || retiredCount !== 32'd0) begin
      errors++; $display("FAIL mid_restart state %0d cnt %0d required 0 0", stateOut, retiredCount);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL mid_pre cycle %0d got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear();
    gen(32'h00500093, 0, 0, 0);
    play();
    checks++;
    if (retiredCount !== 32'd1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL mid_after cnt %0d first %h required 1 %h", retiredCount, obs_q[0], exp_q[0]);
    end
    $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_wrap();
    do_reset();
    clear();
    for (int n = 0; n < 5; n++) gen(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    play();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((obs_b_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL wrap cycle %0d got %h required %h", i, obs_b_q[i], exp_q[i]);
      end
    end
    checks++;
    if (retiredCount !== 32'd5 || retiredCount_b !== 2'd1) begin
      errors++; $display("FAIL wrap_count got %0d/%0d required 5/1", retiredCount, retiredCount_b);
    end
    $display("test_wrap done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instructionCode = '0; imemReady = 1'b0; dmemReady = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_sw_lui();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
